fsm_rr_arbiter: RTL and testbench

Round-robin arbiter that shares a single FSM-controlled resource between NREQ requesters.
- Explicit 4-state registered FSM, so coverage FSM extraction and state/arc attributes apply directly.
- Grants one requester at a time and enforces a maximum hold time.
- Inserts a one-cycle turnaround between grants.
- Serves as the sequencing block in front of the shared toggle-state resource in FSM coverage diagnostics.

---
 rtl/fsm_rr_arbiter.sv | 113 +++++++++++
 tb/tb_fsm_rr_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/fsm_rr_arbiter.sv
// Round-robin arbiter: grants one requester at a time, enforces a hold limit,
// and inserts a one-cycle cool-down between grants.
module fsm_rr_arbiter #(
  parameter int NREQ     = 4,
  parameter int IDW      = 2,
  parameter int MAX_HOLD = 8
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] done,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id,
  output logic [1:0]      state,
  output logic            timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ARB   = 2'b01,
    GRANT = 2'b10,
    COOL  = 2'b11
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t          state_reg;
  logic [NREQ-1:0] gnt_reg;
  logic [IDW-1:0]  gnt_id_reg;
  logic [IDW-1:0]  ptr_reg;
  logic [7:0]      hold_cnt_reg;
  logic            timeout_reg;

  logic [IDW-1:0]  ptr_next;
  logic [NREQ-1:0] req_rot;
  logic [NREQ-1:0] pick_rot;
  logic [NREQ-1:0] seen;
  logic [NREQ-1:0] win_onehot;
  logic [IDW-1:0]  idx_acc [NREQ+1];
  logic [IDW-1:0]  win_idx;
  logic            rel_cond;

  // Rotate requests so bit 0 is the requester at ptr, pick the lowest set bit,
  // then rotate the pick back into requester order.
  assign req_rot    = NREQ'({req, req} >> ptr_reg);
  assign seen[0]    = 1'b0;
  assign win_onehot = NREQ'(({pick_rot, pick_rot} << ptr_reg) >> NREQ);
  assign idx_acc[0] = '0;
  assign win_idx    = idx_acc[NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_pick
    assign pick_rot[gi]  = req_rot[gi] & ~seen[gi];
    assign idx_acc[gi+1] = idx_acc[gi] | ({IDW{win_onehot[gi]}} & IDW'(gi));
    if (gi < NREQ - 1) begin : g_seen
      assign seen[gi+1] = seen[gi] | req_rot[gi];
    end
  end

  assign ptr_next = (gnt_id_reg == IDW'(NREQ - 1)) ? '0 : gnt_id_reg + 1'b1;
  // gnt is one-hot on gnt_id during GRANT, so masking by it selects the grantee's bits.
  assign rel_cond = (|(done & gnt_reg)) | ~(|(req & gnt_reg));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      gnt_reg      <= '0;
      gnt_id_reg   <= '0;
      ptr_reg      <= '0;
      hold_cnt_reg <= '0;
      timeout_reg  <= 1'b0;
    end else begin
      timeout_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (|req) state_reg <= ARB;
        end
        ARB: begin
          if (|req) begin
            gnt_reg      <= win_onehot;
            gnt_id_reg   <= win_idx;
            hold_cnt_reg <= '0;
            state_reg    <= GRANT;
          end else begin
            state_reg <= IDLE;
          end
        end
        GRANT: begin
          if (rel_cond) begin
            gnt_reg   <= '0;
            state_reg <= COOL;
          end else if (hold_cnt_reg == HOLD_LAST) begin
            gnt_reg     <= '0;
            timeout_reg <= 1'b1;
            state_reg   <= COOL;
          end else begin
            hold_cnt_reg <= hold_cnt_reg + 8'd1;
          end
        end
        COOL: begin
          ptr_reg   <= ptr_next;
          state_reg <= (|req) ? ARB : IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign gnt     = gnt_reg;
  assign gnt_id  = gnt_id_reg;
  assign state   = state_reg;
  assign timeout = timeout_reg;

endmodule

// File: tb/tb_fsm_rr_arbiter.sv
// Bench for fsm_rr_arbiter: directed scenarios plus randomized traffic against
// a cycle-level behavioural model.
module tb_fsm_rr_arbiter;
  localparam int NREQ = 4, IDW = 2, MAX_HOLD = 8;

  logic            clock = 1'b0;
  logic            reset_n = 1'b0;
  logic [NREQ-1:0] req = '0;
  logic [NREQ-1:0] done = '0;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_id;
  logic [1:0]      state;
  logic            timeout;

  always #5 clock = ~clock;

  fsm_rr_arbiter #(.NREQ(NREQ), .IDW(IDW), .MAX_HOLD(MAX_HOLD)) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .done(done),
    .gnt(gnt), .gnt_id(gnt_id), .state(state), .timeout(timeout)
  );

  // Model: state number, grantee, search start, cycles already held, timeout flag.
  int m_state, m_id, m_ptr, m_held;
  int m_to;
  int errors = 0, checks = 0, cyc = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_id = 0; m_ptr = 0; m_held = 0; m_to = 0;
  endtask

  task automatic model_step(input logic [NREQ-1:0] r, input logic [NREQ-1:0] d);
    int found;
    m_to = 0;
    case (m_state)
      0: if (r != 0) m_state = 1;
      1: begin
        if (r == 0) m_state = 0;
        else begin
          found = 0;
          for (int k = 0; k < NREQ; k++) begin
            if (found == 0 && ((r >> ((m_ptr + k) % NREQ)) & 1) != 0) begin
              m_id = (m_ptr + k) % NREQ;
              found = 1;
            end
          end
          m_held = 0;
          m_state = 2;
        end
      end
      2: begin
        if (((d >> m_id) & 1) != 0 || ((r >> m_id) & 1) == 0) m_state = 3;
        else if (m_held == MAX_HOLD - 1) begin m_state = 3; m_to = 1; end
        else m_held++;
      end
      default: begin
        m_ptr = (m_id + 1) % NREQ;
        m_state = (r != 0) ? 1 : 0;
      end
    endcase
  endtask

  function automatic int exp_gnt();
    return (m_state == 2) ? (1 << m_id) : 0;
  endfunction

  task automatic compare();
    chk("state", int'(state), m_state);
    chk("gnt", int'(gnt), exp_gnt());
    chk("gnt_id", int'(gnt_id), m_id);
    chk("timeout", int'(timeout), m_to);
    chk("onehot0", int'($onehot0(gnt)), 1);
  endtask

  task automatic cycle(input logic [NREQ-1:0] r, input logic [NREQ-1:0] d);
    req = r; done = d;
    @(posedge clock);
    model_step(r, d);
    cyc++;
    @(negedge clock);
    compare();
    if (m_state == 2 && m_held == 0)
      $display("grant id=%0d cycle=%0d", m_id, cyc);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0; req = '0; done = '0;
    model_reset();
    #1 compare();
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    int exp_states[6];
    int exp_order[5];
    int gid[$], gcyc[$];
    int gcount;
    logic [NREQ-1:0] r, d;
    exp_states = '{1, 2, 2, 2, 3, 0};
    exp_order  = '{0, 1, 2, 3, 0};
    model_reset();

    // 1: single request, done after three grant cycles
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cycle((i < 5) ? 4'b0100 : 4'b0000, (i == 4) ? 4'b0100 : 4'b0000);
      chk("t1_state_seq", int'(state), exp_states[i]);
      chk("t1_timeout", int'(timeout), 0);
    end
    chk("t1_gnt_id", int'(gnt_id), 2);

    // 2: all requesting, one-cycle grants rotate with two-cycle gaps
    do_reset();
    for (int i = 0; i < 40 && gid.size() < 5; i++) begin
      d = (m_state == 2) ? 4'(1 << m_id) : 4'b0000;
      cycle(4'b1111, d);
      if (state == 2'b10) begin gid.push_back(int'(gnt_id)); gcyc.push_back(cyc); end
    end
    chk("t2_count", gid.size(), 5);
    for (int k = 0; k < gid.size(); k++) begin
      chk("t2_order", gid[k], exp_order[k]);
      if (k > 0) chk("t2_gap", gcyc[k] - gcyc[k-1], 3);
    end

    // 3: no done, forced release after MAX_HOLD cycles
    do_reset();
    gcount = 0;
    for (int i = 1; i <= 14; i++) begin
      cycle(4'b0001, 4'b0000);
      if (i >= 2 && i <= 9 && gnt == 4'b0001) gcount++;
      if (i == 10) begin chk("t3_cool", int'(state), 3); chk("t3_timeout_hi", int'(timeout), 1); end
      if (i == 11) begin chk("t3_arb", int'(state), 1); chk("t3_timeout_lo", int'(timeout), 0); end
      if (i == 12) chk("t3_regrant", int'(gnt), 1);
    end
    chk("t3_hold", gcount, 8);

    // 4: done on the last hold cycle beats timeout; foreign done ignored
    do_reset();
    for (int i = 1; i <= 11; i++) begin
      cycle(4'b0001, (i == 4) ? 4'b0010 : (i == 10) ? 4'b0001 : 4'b0000);
      if (i == 4) chk("t4_ignore", int'(gnt), 1);
      if (i == 10) begin chk("t4_cool", int'(state), 3); chk("t4_no_timeout", int'(timeout), 0); end
    end

    // 5: asynchronous reset mid-grant, then search restarts at 0
    do_reset();
    cycle(4'b0100, 4'b0000);
    cycle(4'b0100, 4'b0000);
    cycle(4'b0100, 4'b0000);
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    chk("t5_async_gnt", int'(gnt), 0);
    chk("t5_async_state", int'(state), 0);
    @(negedge clock);
    reset_n = 1'b1;
    cycle(4'b1000, 4'b0000);
    cycle(4'b1000, 4'b0000);
    chk("t5_gnt_id", int'(gnt_id), 3);
    chk("t5_gnt", int'(gnt), 8);

    // 6: request withdrawn during ARB
    do_reset();
    cycle(4'b0010, 4'b0000);
    chk("t6_arb", int'(state), 1);
    cycle(4'b0000, 4'b0000);
    chk("t6_idle", int'(state), 0);
    cycle(4'b0000, 4'b0000);
    chk("t6_no_gnt", int'(gnt), 0);

    // Randomized traffic
    do_reset();
    r = '0;
    for (int i = 0; i < 600; i++) begin
      for (int b = 0; b < NREQ; b++)
        if ($urandom_range(7) == 0) r = r ^ 4'(1 << b);
      d = '0;
      if (m_state == 2 && $urandom_range(3) == 0) d = 4'(1 << m_id);
      if ($urandom_range(5) == 0) d = d | 4'($urandom_range(15));
      cycle(r, d);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
